// File: rtl/xor_mmig_serial.sv
// Serial XOR: SLICE bits of in0^in1 are produced per cycle by a reused bank of xor_mmig cells.
// Define XOR_MMIG_ACC_EN to add accumulate mode (acc_clr port, result folded with the last result).
module xor_mmig (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a ^ b;
endmodule

module xor_mmig_serial #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] op,
`ifdef XOR_MMIG_ACC_EN
  input  logic             acc_clr,
`endif
  output logic             busy
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opa, opb, res, res_nxt, acc_eff;
  logic [SLICE-1:0] sl_a, sl_b, sl_x;
  logic             accept, last, deliver;

  assign accept  = (state == IDLE) && in_valid;
  assign last    = (cnt == CW'(NSLICE - 1));
  assign deliver = (state == DONE) && out_ready;

`ifdef XOR_MMIG_ACC_EN
  logic [WIDTH-1:0] acc;
  // A clear coinciding with capture must already be visible to that operation.
  assign acc_eff = acc_clr ? '0 : acc;

  always_ff @(posedge clk) begin
    if (rst || acc_clr) acc <= '0;
    else if (deliver)   acc <= op;
  end
`else
  assign acc_eff = '0;
`endif

  assign sl_a = opa[cnt*SLICE +: SLICE];
  assign sl_b = opb[cnt*SLICE +: SLICE];

  for (genvar i = 0; i < SLICE; i++) begin : g_cell
    xor_mmig u_cell (.a(sl_a[i]), .b(sl_b[i]), .y(sl_x[i]));
  end

  // Full result including the slice written this cycle, so op can load on the last slice.
  always_comb begin
    res_nxt = res;
    res_nxt[cnt*SLICE +: SLICE] = sl_x;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = BUSY;
      BUSY:    if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state == BUSY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opa <= '0;
      opb <= '0;
      res <= '0;
      op  <= '0;
      cnt <= '0;
    end else begin
      if (accept) begin
        opa <= in0;
        opb <= in1 ^ acc_eff;
        cnt <= '0;
      end
      if (state == BUSY) begin
        res <= res_nxt;
        cnt <= last ? '0 : cnt + CW'(1);
        if (last) op <= res_nxt;
      end
    end
  end
endmodule

// File: tb/tb_xor_mmig_serial.sv
// Randomized self-checking bench for xor_mmig_serial (SLICE=4 and SLICE=16 instances).
module tb_xor_mmig_serial;
  localparam int W  = 16;
  localparam int NS = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [W-1:0] a_in0, a_in1, a_op;
  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [W-1:0] b_in0, b_in1, b_op;
`ifdef XOR_MMIG_ACC_EN
  logic         a_acc_clr, b_acc_clr;
`endif

  xor_mmig_serial #(.WIDTH(W), .SLICE(4)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in0(a_in0), .in1(a_in1), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .op(a_op),
`ifdef XOR_MMIG_ACC_EN
    .acc_clr(a_acc_clr),
`endif
    .busy(a_busy));

  xor_mmig_serial #(.WIDTH(W), .SLICE(16)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in0(b_in0), .in1(b_in1), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .op(b_op),
`ifdef XOR_MMIG_ACC_EN
    .acc_clr(b_acc_clr),
`endif
    .busy(b_busy));

  int           n_chk = 0;
  int           n_err = 0;
  logic [W-1:0] m_acc = '0;   // reference accumulator; stays 0 without accumulate mode

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Entered at a negedge with A idle; returns at a negedge (idle if rdy, else in DONE).
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit clr,
                        input bit rdy, output logic [W-1:0] res);
    logic [W-1:0] exp, op0;
    int lat, nb;
    bit moved;
    a_in0 = x; a_in1 = y; a_in_valid = 1'b1; a_out_ready = rdy;
`ifdef XOR_MMIG_ACC_EN
    a_acc_clr = clr;
`endif
    if (clr) m_acc = '0;
    exp = x ^ y ^ m_acc;
    op0 = a_op;
    @(posedge clk);
    lat = 0; nb = 0; moved = 0;
    while (lat <= 40) begin
      @(negedge clk);
      a_in_valid = 1'b0;
`ifdef XOR_MMIG_ACC_EN
      a_acc_clr = 1'b0;
`endif
      if (a_out_valid) break;
      nb += int'(a_busy);
      if (a_op !== op0) moved = 1;
      @(posedge clk);
      lat++;
    end
    chk("latency", lat, NS);
    chk("busy_cycles", nb, NS);
    chk("op_hold_busy", moved, 0);
    chk("result", a_op, exp);
    res = a_op;
    if (rdy) begin
`ifdef XOR_MMIG_ACC_EN
      m_acc = exp;
`endif
      @(posedge clk);
      @(negedge clk);
      chk("idle_after", {a_in_ready, a_out_valid}, 2'b10);
    end
  endtask

  initial begin
    logic [W-1:0] r, e;
    logic [W-1:0] q[$];
    int stale, cyc, last_acc, n_acc, n_out;
    rst = 1'b1;
    a_in_valid = 0; a_out_ready = 0; a_in0 = '0; a_in1 = '0;
    b_in_valid = 0; b_out_ready = 0; b_in0 = '0; b_in1 = '0;
`ifdef XOR_MMIG_ACC_EN
    a_acc_clr = 0; b_acc_clr = 0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_op", a_op, 0);
    rst = 1'b0;

    // Basic operation
    run_op(16'hA5A5, 16'h0FF0, 1, 1, r);
    chk("basic_op", r, 16'hAA55);

    // Stall in DONE with new operands offered
    run_op(16'hA5A5, 16'h0FF0, 1, 0, r);
    for (int i = 0; i < 10; i++) begin
      a_in_valid = 1'b1; a_in0 = 16'h1111; a_in1 = 16'h2222;
      @(posedge clk); @(negedge clk);
      chk("stall_op", a_op, 16'hAA55);
      chk("stall_in_ready", a_in_ready, 0);
      chk("stall_out_valid", a_out_valid, 1);
    end
    a_out_ready = 1'b1; a_in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("release_idle", {a_in_ready, a_out_valid}, 2'b10);
    chk("release_op", a_op, 16'hAA55);
`ifdef XOR_MMIG_ACC_EN
    m_acc = 16'hAA55;
`endif

    // Reset while BUSY at slice counter 2
    a_in0 = W'($urandom); a_in1 = W'($urandom); a_in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    a_in_valid = 1'b0;
    chk("abort_busy", a_busy, 1);
    repeat (2) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; m_acc = '0;
    chk("abort_in_ready", a_in_ready, 1);
    chk("abort_out_valid", a_out_valid, 0);
    chk("abort_op", a_op, 0);
    chk("abort_busy_low", a_busy, 0);
    stale = 0;
    repeat (6) begin @(posedge clk); @(negedge clk); if (a_out_valid) stale++; end
    chk("abort_no_stale", stale, 0);
    run_op(16'hFFFF, 16'h0001, 0, 1, r);
    chk("post_abort_op", r, 16'hFFFE);

    // Single-slice instance: one-cycle latency
    b_in0 = 16'h1234; b_in1 = 16'h4321; b_in_valid = 1'b1; b_out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    b_in_valid = 1'b0;
    chk("s16_busy", {b_busy, b_out_valid}, 2'b10);
    @(posedge clk); @(negedge clk);
    chk("s16_out_valid", b_out_valid, 1);
    chk("s16_op", b_op, 16'h5115);
    @(posedge clk); @(negedge clk);
    chk("s16_idle", b_in_ready, 1);

`ifdef XOR_MMIG_ACC_EN
    a_acc_clr = 1'b1; @(posedge clk); @(negedge clk); a_acc_clr = 1'b0; m_acc = '0;
    run_op(16'h1234, 16'h0000, 0, 1, r);
    chk("acc_op1", r, 16'h1234);
    run_op(16'h0000, 16'h00FF, 0, 1, r);
    chk("acc_op2", r, 16'h12CB);
    run_op(16'h0001, 16'h0000, 1, 1, r);
    chk("acc_clr_accept", r, 16'h0001);
`endif

    // Back-to-back random operations; operands churn every cycle to show capture is one-shot
    a_out_ready = 1'b1;
    cyc = 0; last_acc = -1; n_acc = 0; n_out = 0;
    while (n_out < 8 && cyc < 300) begin
      a_in0 = W'($urandom); a_in1 = W'($urandom);
      a_in_valid = (n_acc < 8);
      if (a_out_valid) begin
        if (q.size() == 0) chk("b2b_unexpected", 1, 0);
        else begin
          e = q.pop_front();
          chk("b2b_result", a_op, e);
`ifdef XOR_MMIG_ACC_EN
          m_acc = e;
`endif
        end
        n_out++;
      end
      if (a_in_ready && a_in_valid) begin
        q.push_back(a_in0 ^ a_in1 ^ m_acc);
        if (last_acc >= 0) chk("b2b_spacing", cyc - last_acc, NS + 2);
        last_acc = cyc;
        n_acc++;
      end
      @(posedge clk); cyc++;
      @(negedge clk);
    end
    a_in_valid = 1'b0;
    chk("b2b_count", n_out, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
